// File: rtl/logic_op_pipe.sv
// logic_op_pipe: two-stage pipelined 32-bit logic-operation unit (AND/OR/NOR/INV).
// S1 registers A/B/OPRN, S2 registers Y/ZERO. Valid/ready handshakes on both
// sides absorb upstream and downstream stalls without losing data.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   A, B, OPRN           operands and op code (00 AND, 01 OR, 10 NOR, 11 INV)
//   IN_VALID / IN_READY  upstream handshake (IN_READY is combinational)
//   Y, ZERO, OUT_VALID   registered result, zero flag, result-valid
//   OUT_READY            downstream consumes this cycle
//   OPS_DONE             wrapping count of consumed results
//   PARITY               registered XOR-reduction of the result
//                        (present only when LOGIC_OP_PIPE_PARITY_EN is defined)

// 32-bit bitwise AND gate block.
module logic_op_and32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = a & b;
endmodule

// 32-bit bitwise OR gate block.
module logic_op_or32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = a | b;
endmodule

// 32-bit bitwise NOR gate block.
module logic_op_nor32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   assign y = ~(a | b);
endmodule

// 32-bit bitwise inverter block.
module logic_op_inv32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = ~a;
endmodule

module logic_op_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [1:0]            OPRN,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [DATA_WIDTH-1:0] Y,
   output logic                  ZERO,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [CNT_WIDTH-1:0]  OPS_DONE
`ifdef LOGIC_OP_PIPE_PARITY_EN
   ,
   output logic                  PARITY
`endif
);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_NOR = 2'b10;

   // Stage 1 state
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [1:0]            op_q, op_d;
   logic                  s1_valid_q, s1_valid_d;

   // Stage 2 state
   logic [DATA_WIDTH-1:0] y_q, y_d;
   logic                  zero_q, zero_d;
   logic                  out_valid_q, out_valid_d;
   logic [CNT_WIDTH-1:0]  ops_done_q, ops_done_d;
`ifdef LOGIC_OP_PIPE_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic                  s1_adv;
   logic                  in_ready_int;
   logic                  in_accept;
   logic                  out_drain;

   logic [DATA_WIDTH-1:0] and_y, or_y, nor_y, inv_y;
   logic [DATA_WIDTH-1:0] res;

   // Gate-level operation blocks fed from stage 1
   logic_op_and32 #(.WIDTH(DATA_WIDTH)) u_and (.a(a_q), .b(b_q), .y(and_y));
   logic_op_or32  #(.WIDTH(DATA_WIDTH)) u_or  (.a(a_q), .b(b_q), .y(or_y));
   logic_op_nor32 #(.WIDTH(DATA_WIDTH)) u_nor (.a(a_q), .b(b_q), .y(nor_y));
   logic_op_inv32 #(.WIDTH(DATA_WIDTH)) u_inv (.a(a_q), .y(inv_y));

   // Result select by the stage-1 op code
   always_comb begin
      res = inv_y;
      case (op_q)
         OP_AND:  res = and_y;
         OP_OR:   res = or_y;
         OP_NOR:  res = nor_y;
         default: res = inv_y;
      endcase
   end

   // Handshake: S1 moves when S2 is empty or being drained this cycle
   always_comb begin
      s1_adv       = s1_valid_q && (!out_valid_q || OUT_READY);
      in_ready_int = !s1_valid_q || s1_adv;
      in_accept    = IN_VALID && in_ready_int;
      out_drain    = out_valid_q && OUT_READY;
   end

   // Next-state logic for both stages and the completion counter
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      s1_valid_d  = s1_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
      ops_done_d  = ops_done_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      parity_d    = parity_q;
`endif

      // Accept wins over advance so a pass-through keeps s1_valid set
      if (in_accept) begin
         a_d        = A;
         b_d        = B;
         op_d       = OPRN;
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         y_d         = res;
         zero_d      = (res == '0);
         out_valid_d = 1'b1;
`ifdef LOGIC_OP_PIPE_PARITY_EN
         parity_d    = ^res;
`endif
      end else if (out_drain) begin
         out_valid_d = 1'b0;
      end

      if (out_drain) begin
         ops_done_d = ops_done_q + CNT_WIDTH'(1);
      end
   end

   // State registers; reset discards any in-flight operations
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         s1_valid_q  <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
         ops_done_q  <= '0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         s1_valid_q  <= s1_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
         ops_done_q  <= ops_done_d;
`ifdef LOGIC_OP_PIPE_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign IN_READY  = in_ready_int;
   assign Y         = y_q;
   assign ZERO      = zero_q;
   assign OUT_VALID = out_valid_q;
   assign OPS_DONE  = ops_done_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
   assign PARITY    = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed testbench for logic_op_pipe: reset state, each op code, zero flag,
// optional parity, stall/backpressure, mid-operation reset and counter wrap.
module tb_logic_op_pipe;

   logic        CLK;
   logic        RST;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  OPRN;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] Y;
   logic        ZERO;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] OPS_DONE;
`ifdef LOGIC_OP_PIPE_PARITY_EN
   logic        PARITY;
`endif

   int checks   = 0;
   int failures = 0;

   logic_op_pipe dut (
      .CLK       (CLK),
      .RST       (RST),
      .A         (A),
      .B         (B),
      .OPRN      (OPRN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .Y         (Y),
      .ZERO      (ZERO),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OPS_DONE  (OPS_DONE)
`ifdef LOGIC_OP_PIPE_PARITY_EN
      ,
      .PARITY    (PARITY)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Stream n zero-operand ops with OUT_READY high and wait for n consumed results
   task automatic run_stream(input int n);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      A = 32'h0; B = 32'h0; OPRN = 2'b00; OUT_READY = 1'b1;
      while (got < n && cyc < n + 100) begin
         IN_VALID = (sent < n);
         #0;
         if (IN_VALID && IN_READY) sent++;
         if (OUT_VALID && OUT_READY) got++;
         step();
         cyc++;
      end
      IN_VALID = 1'b0;
      check_eq("stream_consumed", 32'(got), 32'(n));
   endtask

   logic [31:0] exp4 [4];
   logic [31:0] op_a [3];
   logic [31:0] op_b [3];
   logic [1:0]  op_c [3];
   int          idx;
   int          accepted;

   initial begin
      RST = 1'b1; A = '0; B = '0; OPRN = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
      #1;
      step(); step();
      RST = 1'b0;
      step();

      // Reset / idle state
      check_eq("rst_y",         Y,                32'h0);
      check_eq("rst_zero",      32'(ZERO),        32'h0);
      check_eq("rst_out_valid", 32'(OUT_VALID),   32'h0);
      check_eq("rst_ops_done",  32'(OPS_DONE),    32'h0);
      check_eq("rst_in_ready",  32'(IN_READY),    32'h1);

      // Back-to-back AND/OR/NOR/INV, one result per cycle
      exp4[0] = 32'hF000_F000;
      exp4[1] = 32'hFFF0_FFF0;
      exp4[2] = 32'h000F_000F;
      exp4[3] = 32'h0F0F_0F0F;
      OUT_READY = 1'b1;
      A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; IN_VALID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         OPRN = 2'(i);
         step();
         if (i >= 1) check_eq($sformatf("b2b_y%0d", i - 1), Y, exp4[i - 1]);
      end
      IN_VALID = 1'b0;
      step();
      check_eq("b2b_y3",         Y,              exp4[3]);
      check_eq("b2b_valid3",     32'(OUT_VALID), 32'h1);
      step();
      check_eq("b2b_drained",    32'(OUT_VALID), 32'h0);
      check_eq("b2b_ops_done",   32'(OPS_DONE),  32'd4);

      // NOR of all-ones gives zero
      A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; OPRN = 2'b10; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step();
      check_eq("nor_y",    Y,         32'h0);
      check_eq("nor_zero", 32'(ZERO), 32'h1);
`ifdef LOGIC_OP_PIPE_PARITY_EN
      check_eq("nor_parity", 32'(PARITY), 32'h0);
`endif
      step();

      // INV of 1
      A = 32'h0000_0001; B = 32'h1234_5678; OPRN = 2'b11; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      step();
      check_eq("inv_y",    Y,         32'hFFFF_FFFE);
      check_eq("inv_zero", 32'(ZERO), 32'h0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
      check_eq("inv_parity", 32'(PARITY), 32'h1);
`endif
      step();
      check_eq("inv_ops_done", 32'(OPS_DONE), 32'd6);

      // Backpressure: 5 stalled cycles, 3 ops offered, only 2 fit
      op_a[0] = 32'h0000_0001; op_b[0] = 32'h0000_0002; op_c[0] = 2'b01; // -> 0x3
      op_a[1] = 32'h0000_00FF; op_b[1] = 32'h0000_000F; op_c[1] = 2'b00; // -> 0xF
      op_a[2] = 32'hFFFF_0000; op_b[2] = 32'h0;         op_c[2] = 2'b11; // -> 0xFFFF
      OUT_READY = 1'b0;
      idx = 0; accepted = 0;
      for (int c = 0; c < 5; c++) begin
         A = op_a[idx]; B = op_b[idx]; OPRN = op_c[idx]; IN_VALID = 1'b1;
         #0;
         if (IN_READY) begin
            accepted++;
            if (idx < 2) idx++;
         end
         step();
      end
      IN_VALID = 1'b0;
      check_eq("stall_accepted",  32'(accepted),  32'd2);
      check_eq("stall_in_ready",  32'(IN_READY),  32'h0);
      check_eq("stall_y_held",    Y,              32'h0000_0003);
      check_eq("stall_valid",     32'(OUT_VALID), 32'h1);
      check_eq("stall_ops_done",  32'(OPS_DONE),  32'd6);
      OUT_READY = 1'b1;
      step();
      check_eq("release_y1",      Y,              32'h0000_000F);
      check_eq("release_valid1",  32'(OUT_VALID), 32'h1);
      step();
      check_eq("release_no_dup",  32'(OUT_VALID), 32'h0);
      check_eq("release_ops",     32'(OPS_DONE),  32'd8);

      // Reset with both stages full
      OUT_READY = 1'b0;
      A = 32'hFFFF_FFFF; B = 32'h1234_5678; OPRN = 2'b00; IN_VALID = 1'b1;
      step(); step();
      check_eq("full_in_ready", 32'(IN_READY),  32'h0);
      check_eq("full_valid",    32'(OUT_VALID), 32'h1);
      RST = 1'b1;
      step();
      RST = 1'b0; IN_VALID = 1'b0;
      check_eq("midrst_valid",    32'(OUT_VALID), 32'h0);
      check_eq("midrst_ops_done", 32'(OPS_DONE),  32'h0);
      check_eq("midrst_y",        Y,              32'h0);
      check_eq("midrst_in_ready", 32'(IN_READY),  32'h1);
      step();
      check_eq("midrst_stays_empty", 32'(OUT_VALID), 32'h0);

      // First op after reset: 2-edge latency
      OUT_READY = 1'b1;
      A = 32'h0000_00A0; B = 32'h0000_0005; OPRN = 2'b01; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      check_eq("post_rst_lat1", 32'(OUT_VALID), 32'h0);
      step();
      check_eq("post_rst_y",     Y,              32'h0000_00A5);
      check_eq("post_rst_valid", 32'(OUT_VALID), 32'h1);
      step();
      check_eq("post_rst_ops",   32'(OPS_DONE),  32'd1);

      // Counter wrap: 65535 results to all-ones, then one more to zero
      RST = 1'b1;
      step();
      RST = 1'b0;
      run_stream(65535);
      check_eq("cnt_all_ones", 32'(OPS_DONE), 32'h0000_FFFF);
      run_stream(1);
      check_eq("cnt_wrap",     32'(OPS_DONE), 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Two-stage pipelined 32-bit logic-operation unit. It registers operands and an op code, evaluates AND / OR / NOR / INV with the team's 32-bit gate-level logic modules, and registers the result with a zero flag. It sits between operand fetch and the ALU result mux, and uses valid/ready handshakes on both sides so upstream and downstream stalls are absorbed without losing data.

## Interface
- `DATA_WIDTH`, 32, operand/result width; fixed at 32 to match the gate modules.
- `CNT_WIDTH`, 16, width of the completed-operation counter.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `A`  in  32  operand A.
- `B`  in  32  operand B; ignored for INV.
- `OPRN`  in  2  op code: 00 AND, 01 OR, 10 NOR, 11 INV (result = ~A).
- `IN_VALID`  in  1  upstream presents A/B/OPRN.
- `IN_READY`  out  1  unit accepts this cycle.
- `Y`  out  32  registered result.
- `ZERO`  out  1  high when Y == 0.
- `OUT_VALID`  out  1  Y/ZERO hold a valid result.
- `OUT_READY`  in  1  downstream consumes this cycle.
- `OPS_DONE`  out  CNT_WIDTH  count of results consumed.

## Operation
- Stage 1 (S1) holds A, B, OPRN and `s1_valid`. Stage 2 (S2) holds Y, ZERO and `OUT_VALID`.
- Input accept: occurs when `IN_VALID && IN_READY`.
- `IN_READY = !s1_valid || s1_adv`, combinational.
- `s1_adv = s1_valid && (!OUT_VALID || OUT_READY)`.
- On `s1_adv`: S2 loads the result of S1's operands and OPRN, and `OUT_VALID <= 1`.
- If S2 drains (`OUT_VALID && OUT_READY`) and `s1_adv` is low: `OUT_VALID <= 0`. Y and ZERO keep their last values.
- S1 loads on accept. Otherwise `s1_valid` clears on `s1_adv`. Accept and advance in the same cycle are both performed (pass-through, `s1_valid` stays 1).
- The result path is combinational between S1 and S2, built by instancing the 32-bit AND, OR, NOR and INV modules and selecting the result by OPRN.
- ZERO is computed from the selected result before it is registered.
- `OPS_DONE` increments by 1 on each `OUT_VALID && OUT_READY`. It wraps from all-ones to 0.
- Stall rule: while `OUT_VALID && !OUT_READY`, Y, ZERO and OUT_VALID hold stable. S1 holds if it is full.
- Full condition: both stages valid and OUT_READY low. IN_READY is then 0 and A/B/OPRN are ignored.
- Empty condition: `s1_valid = 0` and `OUT_VALID = 0`. IN_READY is 1 and OUT_VALID is 0.
- Reset, including mid-operation: `s1_valid`, `OUT_VALID`, Y, ZERO and `OPS_DONE` all go to 0 at the edge. In-flight operations are discarded and not counted. RST has priority over every handshake.
- Reset values: Y = 0, ZERO = 0, OUT_VALID = 0, OPS_DONE = 0, IN_READY = 1 (follows from `s1_valid = 0`).

## Timing
- Latency: operands accepted at edge k appear on Y with OUT_VALID = 1 after edge k+1 (the S1→S2 transfer at edge k+1), provided S2 is free. This is 2 register stages from input pins to Y.
- Throughput: 1 result per cycle with OUT_READY held high.
- IN_READY has a combinational path from OUT_READY through `s1_adv`. No combinational path exists from A/B to Y.
- One stall cycle on OUT_READY delays every queued result by exactly 1 cycle, with no loss and no duplication.

## Configuration
- `LOGIC_OP_PIPE_PARITY_EN`
  - Defined: adds output port `PARITY` (1 bit), the registered XOR-reduction of the selected result. It is loaded with Y, held under stall, and resets to 0.
  - Undefined: no `PARITY` port and no parity logic. All other behaviour is identical.

## Test plan
- Reset then idle → Y = 0, ZERO = 0, OUT_VALID = 0, OPS_DONE = 0, IN_READY = 1.
- A = 0xF0F0_F0F0, B = 0xFF00_FF00, sent as OPRN 00, 01, 10, 11 on back-to-back cycles with OUT_READY = 1 → Y = 0xF000_F000, 0xFFF0_FFF0, 0x000F_000F, 0x0F0F_0F0F, one per cycle. OPS_DONE = 4.
- NOR with A = B = 0xFFFF_FFFF → Y = 0, ZERO = 1. With `LOGIC_OP_PIPE_PARITY_EN` defined, PARITY = 0. INV with A = 0x0000_0001 → Y = 0xFFFF_FFFE, PARITY = 1.
- OUT_READY = 0 for 5 cycles while 3 ops are offered → exactly 2 accepted, IN_READY = 0 afterwards, Y stable. Releasing OUT_READY delivers results in order with no duplicates.
- RST asserted for one cycle with both stages full → next cycle OUT_VALID = 0 and OPS_DONE = 0. The first op after reset produces a correct result 2 edges after acceptance.
- Preload OPS_DONE to 0xFFFF by consuming 65535 results, then consume 1 more → OPS_DONE = 0x0000.
